// File: rtl/bht_pkg.sv
// Shared 2-bit hysteresis counter encoding and update rule for the branch history table.
package bht_pkg;

    localparam int BHT_AW = 10;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // A weak state that sees its own direction jumps straight to the strong state.
    function automatic logic [1:0] next_ctr(input logic [1:0] c, input logic t);
        logic [1:0] n;
        if (t) n = (c == SNT) ? WNT : ST;
        else   n = (c == ST)  ? WT  : SNT;
        return n;
    endfunction

endpackage

// File: rtl/bht_inflight_q.sv
// In-order queue of looked-up branches {addr, counter}; a push is visible at the head one cycle later.
// No internal backpressure: pushes when full and pops when empty are ignored; same-address entries can be rewritten in parallel.
module bht_inflight_q
    import bht_pkg::*;
#(
    parameter int  AW    = BHT_AW,
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [AW-1:0] push_addr_i,
    input  logic [1:0]    push_ctr_i,
    input  logic          pop_i,
    input  logic          upd_en_i,
    input  logic [AW-1:0] upd_addr_i,
    input  logic [1:0]    upd_ctr_i,
    output logic [AW-1:0] head_addr_o,
    output logic [1:0]    head_ctr_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [PW:0]   count_o
);

    logic [AW-1:0] addr_q [DEPTH];
    logic [1:0]    ctr_q  [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o      = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o     = (cnt_q == '0);
    assign do_push     = push_i && !full_o;
    assign do_pop      = pop_i && !empty_o;
    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_ctr_o  = ctr_q[rd_ptr_q];
    assign count_o     = cnt_q;

    always_comb begin
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        cnt_d    = cnt_q + {PW'(0), do_push} - {PW'(0), do_pop};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                ctr_q[i]  <= SNT;
            end
        end else begin
            // Stale slots may also match; harmless since a push rewrites them before use.
            for (int i = 0; i < DEPTH; i++) begin
                if (upd_en_i && addr_q[i] == upd_addr_i) ctr_q[i] <= upd_ctr_i;
            end
            if (do_push) begin
                addr_q[wr_ptr_q] <= push_addr_i;
                ctr_q[wr_ptr_q]  <= push_ctr_i;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/bht_update_ctrl.sv
// BHT front end: combinational prediction, in-flight tracking, one table write the cycle after each resolve.
// Lookups stall while the queue is full or a write owns the shared table address.
module bht_update_ctrl
    import bht_pkg::*;
#(
    parameter int AW    = BHT_AW,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   lk_valid,
    input  logic [AW-1:0]          lk_addr,
    output logic                   lk_ready,
    output logic                   pred_taken,
    input  logic                   res_valid,
    input  logic                   res_taken,
    input  logic [1:0]             bht_rdata,
    output logic [AW-1:0]          bht_addr,
    output logic [1:0]             bht_wdata,
    output logic                   bht_wr,
    output logic                   mispredict,
    output logic                   underflow,
    output logic [CNT_W-1:0]       mp_count,
    output logic [$clog2(DEPTH):0] inflight
);

    logic             wr_pending_q, wr_pending_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [1:0]       wr_data_q, wr_data_d;
    logic             mispredict_q, mispredict_d;
    logic             underflow_q, underflow_d;
    logic [CNT_W-1:0] mp_count_q, mp_count_d;

    logic             q_full, q_empty, push, pop;
    logic [AW-1:0]    head_addr;
    logic [1:0]       head_ctr, nxt, push_ctr;

    assign lk_ready   = !q_full && !wr_pending_q;
    assign push       = lk_valid && lk_ready;
    assign pop        = res_valid && !q_empty;
    assign nxt        = next_ctr(head_ctr, res_taken);
    // The table still holds the old counter for ha this cycle, so a same-address push takes the new one.
    assign push_ctr   = (pop && lk_addr == head_addr) ? nxt : bht_rdata;
    assign pred_taken = bht_rdata[1];
    assign bht_addr   = wr_pending_q ? wr_addr_q : lk_addr;
    assign bht_wdata  = wr_data_q;
    assign bht_wr     = wr_pending_q;
    assign mispredict = mispredict_q;
    assign underflow  = underflow_q;
    assign mp_count   = mp_count_q;

    bht_inflight_q #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_q (
        .clk_i       (CLK),
        .rst_i       (RST),
        .push_i      (push),
        .push_addr_i (lk_addr),
        .push_ctr_i  (push_ctr),
        .pop_i       (pop),
        .upd_en_i    (pop),
        .upd_addr_i  (head_addr),
        .upd_ctr_i   (nxt),
        .head_addr_o (head_addr),
        .head_ctr_o  (head_ctr),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .count_o     (inflight)
    );

    always_comb begin
        wr_pending_d = pop;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        if (pop) begin
            wr_addr_d = head_addr;
            wr_data_d = nxt;
        end
        mispredict_d = pop && (head_ctr[1] != res_taken);
        underflow_d  = res_valid && q_empty;
        mp_count_d   = mp_count_q;
        if (mispredict_d && mp_count_q != '1) mp_count_d = mp_count_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_pending_q <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= SNT;
            mispredict_q <= 1'b0;
            underflow_q  <= 1'b0;
            mp_count_q   <= '0;
        end else begin
            wr_pending_q <= wr_pending_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            mispredict_q <= mispredict_d;
            underflow_q  <= underflow_d;
            mp_count_q   <= mp_count_d;
        end
    end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed bench for bht_update_ctrl with a behavioural 1024x2 table attached to the shared port.
module tb_bht_update_ctrl;

    localparam int AW    = 10;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic                   CLK = 1'b0;
    logic                   RST = 1'b1;
    logic                   lk_valid, res_valid, res_taken;
    logic [AW-1:0]          lk_addr;
    logic                   lk_ready, pred_taken, bht_wr, mispredict, underflow;
    logic [1:0]             bht_rdata, bht_wdata;
    logic [AW-1:0]          bht_addr;
    logic [CNT_W-1:0]       mp_count;
    logic [$clog2(DEPTH):0] inflight;

    logic [1:0] mem [0:1023] = '{default: 2'b00};

    int n_pass = 0;
    int n_chk  = 0;

    always #5 CLK = ~CLK;

    assign bht_rdata = mem[bht_addr];
    always @(posedge CLK) if (bht_wr) mem[bht_addr] <= bht_wdata;

    bht_update_ctrl #(.AW(AW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .lk_valid   (lk_valid),
        .lk_addr    (lk_addr),
        .lk_ready   (lk_ready),
        .pred_taken (pred_taken),
        .res_valid  (res_valid),
        .res_taken  (res_taken),
        .bht_rdata  (bht_rdata),
        .bht_addr   (bht_addr),
        .bht_wdata  (bht_wdata),
        .bht_wr     (bht_wr),
        .mispredict (mispredict),
        .underflow  (underflow),
        .mp_count   (mp_count),
        .inflight   (inflight)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Drive one cycle's inputs after the falling edge; checks follow before the next rising edge.
    task automatic cyc(input logic lv, input logic [AW-1:0] la, input logic rv, input logic rt);
        @(negedge CLK);
        lk_valid  = lv;
        lk_addr   = la;
        res_valid = rv;
        res_taken = rt;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic lookup(input logic [AW-1:0] a);
        cyc(1'b1, a, 1'b0, 1'b0);
    endtask

    task automatic resolve(input logic t);
        cyc(1'b0, '0, 1'b1, t);
    endtask

    logic [1:0] seq_exp [5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
    logic       seq_t   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        lk_valid = 1'b0; lk_addr = '0; res_valid = 1'b0; res_taken = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        idle();
        check("rst_inflight", 32'(inflight), 0);
        check("rst_bht_wr", 32'(bht_wr), 0);
        check("rst_mispredict", 32'(mispredict), 0);
        check("rst_underflow", 32'(underflow), 0);
        check("rst_mp_count", 32'(mp_count), 0);
        check("rst_lk_ready", 32'(lk_ready), 1);

        // Single lookup/resolve on addr 5
        lookup(10'd5);
        check("t1_pred", 32'(pred_taken), 0);
        resolve(1'b1);
        check("t1_inflight", 32'(inflight), 1);
        idle();
        check("t1_bht_wr", 32'(bht_wr), 1);
        check("t1_bht_addr", 32'(bht_addr), 5);
        check("t1_bht_wdata", 32'(bht_wdata), 1);
        check("t1_mispredict", 32'(mispredict), 1);
        check("t1_mp_count", 32'(mp_count), 1);
        check("t1_lk_ready", 32'(lk_ready), 0);
        check("t1_inflight0", 32'(inflight), 0);
        idle();
        check("t1_wr_clear", 32'(bht_wr), 0);
        check("t1_mp_clear", 32'(mispredict), 0);
        check("t1_mem5", 32'(mem[5]), 1);

        // Bring addr 7 to 01, then two in-flight copies of it
        lookup(10'd7);
        resolve(1'b1);
        idle();
        idle();
        check("t2_mem7", 32'(mem[7]), 1);
        lookup(10'd7);
        check("t2_pred", 32'(pred_taken), 0);
        lookup(10'd7);
        resolve(1'b1);
        check("t2_inflight2", 32'(inflight), 2);
        resolve(1'b1);
        check("t2_w1_wr", 32'(bht_wr), 1);
        check("t2_w1_addr", 32'(bht_addr), 7);
        check("t2_w1_wdata", 32'(bht_wdata), 3);
        check("t2_w1_mp", 32'(mispredict), 1);
        check("t2_w1_mp_count", 32'(mp_count), 3);
        check("t2_w1_ready", 32'(lk_ready), 0);
        idle();
        check("t2_w2_wr", 32'(bht_wr), 1);
        check("t2_w2_wdata", 32'(bht_wdata), 3);
        check("t2_w2_mp", 32'(mispredict), 0);
        check("t2_w2_mp_count", 32'(mp_count), 3);
        check("t2_w2_ready", 32'(lk_ready), 0);
        idle();
        check("t2_wr_clear", 32'(bht_wr), 0);

        // Fill, then push/pop at full and at three entries
        for (int i = 0; i < 4; i++) lookup(AW'(20 + i));
        cyc(1'b1, 10'd30, 1'b1, 1'b0);
        check("t3_full_inflight", 32'(inflight), 4);
        check("t3_full_ready", 32'(lk_ready), 0);
        idle();
        check("t3_after_inflight", 32'(inflight), 3);
        check("t3_wr_addr", 32'(bht_addr), 20);
        check("t3_wr_wdata", 32'(bht_wdata), 0);
        cyc(1'b1, 10'd31, 1'b1, 1'b0);
        check("t3_ready3", 32'(lk_ready), 1);
        idle();
        check("t3_inflight_same", 32'(inflight), 3);
        repeat (3) resolve(1'b0);
        idle();
        idle();
        check("t3_drained", 32'(inflight), 0);
        check("t3_mp_count", 32'(mp_count), 3);

        // Resolve with nothing in flight
        resolve(1'b1);
        idle();
        check("t4_underflow", 32'(underflow), 1);
        check("t4_bht_wr", 32'(bht_wr), 0);
        check("t4_mp_count", 32'(mp_count), 3);
        idle();
        check("t4_underflow_pulse", 32'(underflow), 0);

        // Counter walk on addr 9
        for (int i = 0; i < 5; i++) begin
            lookup(10'd9);
            resolve(seq_t[i]);
            idle();
            check($sformatf("t5_wr%0d", i), 32'(bht_wr), 1);
            check($sformatf("t5_addr%0d", i), 32'(bht_addr), 9);
            check($sformatf("t5_wdata%0d", i), 32'(bht_wdata), 32'(seq_exp[i]));
        end
        idle();
        check("t5_mp_count", 32'(mp_count), 8);

        // Reset with a write pending and three branches in flight
        for (int i = 0; i < 4; i++) lookup(AW'(40 + i));
        resolve(1'b1);
        idle();
        check("t6_pre_inflight", 32'(inflight), 3);
        check("t6_pre_wr", 32'(bht_wr), 1);
        RST = 1'b1;
        #1;
        check("t6_rst_wr", 32'(bht_wr), 0);
        check("t6_rst_inflight", 32'(inflight), 0);
        check("t6_rst_mp_count", 32'(mp_count), 0);
        check("t6_rst_mispredict", 32'(mispredict), 0);
        @(posedge CLK);
        #1;
        check("t6_no_write", 32'(mem[40]), 0);
        check("t6_wr_held", 32'(bht_wr), 0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("t6_ready", 32'(lk_ready), 1);
        check("t6_inflight", 32'(inflight), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
